block_scroller: RTL and testbench
=================================

# block_scroller

Obstacle scroller that owns the four on-screen block slots and drives the display stage's `BLOCK_SHAPE`, `BLOCK_START_X` and `BLOCK_COLOR` buses. Once per video frame, in vertical blanking, it moves every active block left by `SPEED` pixels. It retires blocks that have left the screen and spawns new random blocks at the right edge, keeping a minimum horizontal gap between them. It sits directly upstream of the VGA output stage and takes that stage's `V_SYNC` as its frame reference.

## Interface

**Parameters**

- `SHAPE_W`, 4: shape code width per slot. Code 0 = no block.
- `COORD_W`, 10: x coordinate width.
- `COLOR_W`, 3: color code width per slot.
- `X_MIN`, 143: x of the leftmost visible pixel.
- `X_MAX`, 783: spawn x, i.e. the right screen edge.
- `BLOCK_W`, 80: block width in pixels.
- `MIN_GAP`, 160: minimum spawn spacing in pixels.

**Ports**

- `CLK`, in, 1: 100 MHz board clock.
- `RESET_N`, in, 1: asynchronous, active-low reset.
- `ENABLE`, in, 1: 1 = scrolling runs; 0 = positions frozen.
- `V_SYNC`, in, 1: vertical sync from the VGA counter, asynchronous to `CLK`.
- `SPEED`, in, 4: pixels moved per frame, 0..15.
- `RANDOM`, in, 12: free-running random word.
- `BLOCK_SHAPE`, out, 4*SHAPE_W: slot 1 in the MSBs, slot 4 in the LSBs.
- `BLOCK_START_X`, out, 4*COORD_W: left x per slot, same slot order.
- `BLOCK_COLOR`, out, 4*COLOR_W: color code per slot, same slot order.
- `PASSED`, out, 1: 1-cycle pulse per retired block (score increment).
- `UPDATING`, out, 1: 1 while an update sequence is in progress.

## Operation

**Frame tick**

- `V_SYNC` goes through a 2-flop synchronizer.
- A falling edge of the synchronized signal is the frame tick: one cycle wide.

**State machine**

- **IDLE**
  - Wait for a tick with `ENABLE`=1, then go to UPD0.
  - A tick with `ENABLE`=0 is ignored; all slots hold.
- **UPD0..UPD3** (one cycle per slot, slot 1..4)
  - Inactive slot: no change.
  - Active slot with x <= X_MIN − BLOCK_W + SPEED: retire. Shape := 0, x := 0, color := 0, `PASSED` pulses in that cycle.
  - Any other active slot: x := x − SPEED.
  - UPD3 also decrements the gap counter by `SPEED`, saturating at 0.
  - UPD3 goes to SPAWN.
- **SPAWN** (one cycle, then IDLE)
  - Condition: gap counter = 0 and at least one slot has shape 0.
  - If met, fill the lowest-numbered free slot:
    - shape := RANDOM[2:0], or 1 if that is 0; upper shape bits 0.
    - color := RANDOM[5:3], or 1 if that is 0.
    - x := X_MAX.
  - Gap counter := MIN_GAP + RANDOM[11:7], range 160..191.
  - If no slot is free, the gap counter stays 0 and the spawn retries next frame.

**Arithmetic**

- x is unsigned COORD_W bits.
- The retire compare is evaluated before subtraction, so x never wraps below 0.
- The gap counter is 9 bits.

**Boundaries**

- `SPEED`=0: nothing moves, nothing retires, gap does not decrement. A spawn still happens if the gap is already 0.
- A tick arriving during UPD0..SPAWN is dropped.
- `ENABLE` falling mid-sequence: the sequence completes; the next tick is ignored.
- `RESET_N` low at any time, including mid-sequence:
  - All slots cleared to shape 0, x 0, color 0.
  - Gap counter := 0, state := IDLE, synchronizer flops := 1.
  - `PASSED` and `UPDATING` := 0.

## Timing

- All outputs are registered.
- Reset value of every output is 0.
- Tick detection latency: 3 `CLK` cycles after `V_SYNC` falls.
- The sequence takes 5 cycles after the tick (UPD0–UPD3, SPAWN).
- `UPDATING` = 1 exactly during UPD0..SPAWN.
- Slot k's outputs change only in its UPDk cycle or in SPAWN. They are otherwise stable for the whole frame, which keeps the display stage glitch-free.
- `PASSED` is at most one pulse per UPD cycle, so up to 4 per frame.

## Test plan

1. **Reset, first spawn:** hold `RESET_N`=0, release, `ENABLE`=1, one `V_SYNC` fall, `RANDOM`=0x0_2B (RANDOM[2:0]=3, RANDOM[5:3]=5) → after 8 cycles slot 1 has shape 3, x 783, color 5; gap counter 160; slots 2–4 shape 0.
2. **Scrolling:** `SPEED`=4, 10 ticks after the spawn → slot 1 x = 743; slot 2 still empty while gap > 0. The gap reaches 0 after 40 ticks, and slot 2 spawns at 783 on tick 40.
3. **Retire:** preload slot 1 x=67, `SPEED`=4 (67 <= 143−80+4) → on the next tick, shape 0, x 0, `PASSED` high for exactly one cycle, during UPD0.
4. **Zero substitution:** `RANDOM`=0x000 at spawn → shape 1, color 1, gap 160.
5. **Freeze, slots full:** with all 4 slots full, `ENABLE`=0 then 5 ticks → no output changes and `UPDATING` stays 0. Re-enable → no spawn until a slot retires.
6. **Reset mid-sequence:** assert `RESET_N`=0 during UPD2 → all outputs 0 immediately (asynchronously); after release, the first tick is handled normally from IDLE.

Source files
------------

// File: rtl/block_scroller.sv
// ============================================================================
// block_scroller : per-frame obstacle scroller for four on-screen block slots
// Revision 1.0
// ============================================================================
`default_nettype none

module block_scroller #(
  parameter int SHAPE_W = 4,
  parameter int COORD_W = 10,
  parameter int COLOR_W = 3,
  parameter int X_MIN   = 143,
  parameter int X_MAX   = 783,
  parameter int BLOCK_W = 80,
  parameter int MIN_GAP = 160
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  input  logic                   V_SYNC,
  input  logic [3:0]             SPEED,
  input  logic [11:0]            RANDOM,
  output logic [4*SHAPE_W-1:0]   BLOCK_SHAPE,
  output logic [4*COORD_W-1:0]   BLOCK_START_X,
  output logic [4*COLOR_W-1:0]   BLOCK_COLOR,
  output logic                   PASSED,
  output logic                   UPDATING
);

  localparam logic [COORD_W:0] RETIRE_BASE = (COORD_W+1)'(X_MIN - BLOCK_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UPD0  = 3'd1,
    UPD1  = 3'd2,
    UPD2  = 3'd3,
    UPD3  = 3'd4,
    SPAWN = 3'd5
  } state_t;

  state_t state, state_next;

  logic vs_meta, vs_sync, vs_prev;
  logic tick;

  logic [SHAPE_W-1:0] shape [4];
  logic [COORD_W-1:0] xpos  [4];
  logic [COLOR_W-1:0] color [4];
  logic [8:0]         gap;

  logic               in_upd;
  logic [1:0]         upd_idx;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W:0]   retire_lim;
  logic               slot_active;
  logic               retire;
  logic               free_found;
  logic [1:0]         free_idx;
  logic [2:0]         new_shape;
  logic [2:0]         new_color;
  logic               unused_random;

  assign unused_random = RANDOM[6];

  // Synchronizer idles high so a reset never manufactures a falling edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= V_SYNC;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign tick = vs_prev & ~vs_sync;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick && ENABLE) state_next = UPD0;
      UPD0:    state_next = UPD1;
      UPD1:    state_next = UPD2;
      UPD2:    state_next = UPD3;
      UPD3:    state_next = SPAWN;
      SPAWN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // UPD0..UPD3 encode as 1..4, so the low two bits minus one give slot 0..3.
  assign in_upd      = (state == UPD0) || (state == UPD1) || (state == UPD2) || (state == UPD3);
  assign upd_idx     = state[1:0] - 2'd1;
  assign cur_x       = xpos[upd_idx];
  assign slot_active = (shape[upd_idx] != '0);
  assign retire_lim  = RETIRE_BASE + (COORD_W+1)'(SPEED);
  assign retire      = in_upd && slot_active && ({1'b0, cur_x} <= retire_lim);

  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (shape[k] == '0) begin
        free_found = 1'b1;
        free_idx   = 2'(k);
      end
    end
  end

  assign new_shape = (RANDOM[2:0] == 3'd0) ? 3'd1 : RANDOM[2:0];
  assign new_color = (RANDOM[5:3] == 3'd0) ? 3'd1 : RANDOM[5:3];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < 4; k++) begin
        shape[k] <= '0;
        xpos[k]  <= '0;
        color[k] <= '0;
      end
      gap      <= 9'd0;
      PASSED   <= 1'b0;
      UPDATING <= 1'b0;
    end else begin
      PASSED   <= 1'b0;
      UPDATING <= (state_next != IDLE);

      if (in_upd && slot_active) begin
        if (retire) begin
          shape[upd_idx] <= '0;
          xpos[upd_idx]  <= '0;
          color[upd_idx] <= '0;
          PASSED         <= 1'b1;
        end else begin
          xpos[upd_idx] <= cur_x - COORD_W'(SPEED);
        end
      end

      if (state == UPD3) begin
        gap <= (gap > 9'(SPEED)) ? gap - 9'(SPEED) : 9'd0;
      end

      // With every slot occupied the gap stays at zero and the spawn retries.
      if ((state == SPAWN) && (gap == 9'd0) && free_found) begin
        shape[free_idx] <= SHAPE_W'(new_shape);
        color[free_idx] <= COLOR_W'(new_color);
        xpos[free_idx]  <= COORD_W'(X_MAX);
        gap             <= 9'(MIN_GAP) + 9'(RANDOM[11:7]);
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign BLOCK_SHAPE[(3-g)*SHAPE_W +: SHAPE_W]   = shape[g];
    assign BLOCK_START_X[(3-g)*COORD_W +: COORD_W] = xpos[g];
    assign BLOCK_COLOR[(3-g)*COLOR_W +: COLOR_W]   = color[g];
  end

endmodule

`default_nettype wire

// File: tb/tb_block_scroller.sv
// ============================================================================
// tb_block_scroller : randomized self-checking bench with a frame-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_block_scroller;

  localparam int SW = 4;
  localparam int CW = 10;
  localparam int KW = 3;
  localparam int X_MIN   = 143;
  localparam int X_MAX   = 783;
  localparam int BLOCK_W = 80;
  localparam int MIN_GAP = 160;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            ENABLE = 1'b0;
  logic            V_SYNC = 1'b1;
  logic [3:0]      SPEED = 4'd0;
  logic [11:0]     RANDOM = 12'd0;
  logic [4*SW-1:0] BLOCK_SHAPE;
  logic [4*CW-1:0] BLOCK_START_X;
  logic [4*KW-1:0] BLOCK_COLOR;
  logic            PASSED;
  logic            UPDATING;

  int n_checks = 0;
  int n_pass   = 0;

  int m_shape [4];
  int m_x     [4];
  int m_color [4];
  int m_gap;
  int slot1_chg;
  int last_pass_mask;

  block_scroller dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .V_SYNC(V_SYNC),
    .SPEED(SPEED), .RANDOM(RANDOM), .BLOCK_SHAPE(BLOCK_SHAPE),
    .BLOCK_START_X(BLOCK_START_X), .BLOCK_COLOR(BLOCK_COLOR),
    .PASSED(PASSED), .UPDATING(UPDATING)
  );

  always #5 CLK = ~CLK;

  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      m_shape[k] = 0; m_x[k] = 0; m_color[k] = 0;
    end
    m_gap = 0;
  endfunction

  // One enabled frame: move or retire each slot, drain the gap, maybe spawn.
  function automatic int model_frame(input bit en);
    int mask = 0;
    int spd = int'(SPEED);
    int rnd = int'(RANDOM);
    int sh, co;
    if (!en) return 0;
    for (int k = 0; k < 4; k++) begin
      if (m_shape[k] != 0) begin
        if (m_x[k] <= X_MIN - BLOCK_W + spd) begin
          m_shape[k] = 0; m_x[k] = 0; m_color[k] = 0;
          mask |= (1 << (4 + k));
        end else begin
          m_x[k] -= spd;
        end
      end
    end
    m_gap = (m_gap > spd) ? m_gap - spd : 0;
    if (m_gap == 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_shape[k] == 0) begin
          sh = rnd % 8;        if (sh == 0) sh = 1;
          co = (rnd / 8) % 8;  if (co == 0) co = 1;
          m_shape[k] = sh; m_color[k] = co; m_x[k] = X_MAX;
          m_gap = MIN_GAP + (rnd / 128) % 32;
          break;
        end
      end
    end
    return mask;
  endfunction

  function automatic bit model_full();
    for (int k = 0; k < 4; k++) if (m_shape[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic compare_model(input string tag);
    logic [4*SW-1:0] es;
    logic [4*CW-1:0] ex;
    logic [4*KW-1:0] ec;
    for (int k = 0; k < 4; k++) begin
      es[(3-k)*SW +: SW] = SW'(m_shape[k]);
      ex[(3-k)*CW +: CW] = CW'(m_x[k]);
      ec[(3-k)*KW +: KW] = KW'(m_color[k]);
    end
    n_checks++;
    if (BLOCK_SHAPE !== es) $display("FAIL %s shape: got %h want %h", tag, BLOCK_SHAPE, es);
    else n_pass++;
    n_checks++;
    if (BLOCK_START_X !== ex) $display("FAIL %s x: got %h want %h", tag, BLOCK_START_X, ex);
    else n_pass++;
    n_checks++;
    if (BLOCK_COLOR !== ec) $display("FAIL %s color: got %h want %h", tag, BLOCK_COLOR, ec);
    else n_pass++;
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    V_SYNC  = 1'b1;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    model_clear();
    repeat (2) @(negedge CLK);
  endtask

  // Drives one V_SYNC fall (optionally a second, dropped one) and checks the frame.
  task automatic run_frame(input bit en, input bit drop_mid, input bit dbl, input string tag);
    int exp_mask, pass_mask, upd_cnt, bad;
    logic [4*SW-1:0] ps;
    logic [4*CW-1:0] px;
    logic [4*KW-1:0] pc;
    ENABLE   = en;
    exp_mask = model_frame(en);
    pass_mask = 0; upd_cnt = 0; bad = 0; slot1_chg = 0;
    ps = BLOCK_SHAPE; px = BLOCK_START_X; pc = BLOCK_COLOR;
    V_SYNC = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge CLK);
      if (dbl && i == 1) V_SYNC = 1'b1;
      if (dbl && i == 2) V_SYNC = 1'b0;
      if (drop_mid && i == 4) ENABLE = 1'b0;
      if (UPDATING) upd_cnt++;
      if (PASSED) pass_mask |= (1 << i);
      for (int k = 0; k < 4; k++) begin
        if ({ps[(3-k)*SW +: SW], px[(3-k)*CW +: CW], pc[(3-k)*KW +: KW]} !==
            {BLOCK_SHAPE[(3-k)*SW +: SW], BLOCK_START_X[(3-k)*CW +: CW], BLOCK_COLOR[(3-k)*KW +: KW]}) begin
          if (k == 0) slot1_chg |= (1 << i);
          if (i != 4 + k && i != 8) bad++;
        end
      end
      ps = BLOCK_SHAPE; px = BLOCK_START_X; pc = BLOCK_COLOR;
    end
    V_SYNC = 1'b1;
    repeat (4) @(negedge CLK);
    last_pass_mask = pass_mask;
    compare_model(tag);
    n_checks++;
    if (upd_cnt !== (en ? 5 : 0)) $display("FAIL %s updating_cycles: got %0d want %0d", tag, upd_cnt, en ? 5 : 0);
    else n_pass++;
    n_checks++;
    if (pass_mask !== exp_mask) $display("FAIL %s passed_pulses: got %h want %h", tag, pass_mask, exp_mask);
    else n_pass++;
    n_checks++;
    if (bad !== 0) $display("FAIL %s slot_change_outside_window: got %0d want 0", tag, bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({BLOCK_SHAPE, BLOCK_START_X, BLOCK_COLOR, PASSED, UPDATING} !== '0)
      $display("FAIL reset_held outputs: got %h want 0", {BLOCK_SHAPE, BLOCK_START_X, BLOCK_COLOR, PASSED, UPDATING});
    else n_pass++;
    apply_reset();
    compare_model("reset_released");
  endtask

  task automatic test_first_spawn();
    SPEED  = 4'd4;
    RANDOM = 12'h02B;
    run_frame(1'b1, 1'b0, 1'b0, "first_spawn");
    n_checks++;
    if (slot1_chg !== (1 << 8)) $display("FAIL first_spawn latency_mask: got %h want %h", slot1_chg, 1 << 8);
    else n_pass++;
    n_checks++;
    if ({BLOCK_SHAPE[15:12], BLOCK_START_X[39:30], BLOCK_COLOR[11:9]} !== {4'd3, 10'd783, 3'd5})
      $display("FAIL first_spawn slot1: got %h want %h", {BLOCK_SHAPE[15:12], BLOCK_START_X[39:30], BLOCK_COLOR[11:9]}, {4'd3, 10'd783, 3'd5});
    else n_pass++;
  endtask

  // Gap bits forced high so slot 1 is empty after it retires.
  task automatic test_scroll();
    for (int f = 1; f <= 40; f++) begin
      RANDOM = {5'h1F, 7'($urandom)};
      run_frame(1'b1, 1'b0, 1'b0, $sformatf("scroll_%0d", f));
      if (f == 10) begin
        n_checks++;
        if (BLOCK_START_X[39:30] !== 10'd743) $display("FAIL scroll slot1_x: got %0d want 743", BLOCK_START_X[39:30]);
        else n_pass++;
      end
      if (f == 39) begin
        n_checks++;
        if (BLOCK_SHAPE[11:8] !== 4'd0) $display("FAIL scroll slot2_early: got %0d want 0", BLOCK_SHAPE[11:8]);
        else n_pass++;
      end
    end
    n_checks++;
    if (BLOCK_SHAPE[11:8] === 4'd0 || BLOCK_START_X[29:20] !== 10'd783)
      $display("FAIL scroll slot2_spawn: got shape %0d x %0d want nonzero/783", BLOCK_SHAPE[11:8], BLOCK_START_X[29:20]);
    else n_pass++;
  endtask

  task automatic test_retire();
    for (int f = 41; f <= 179; f++) begin
      RANDOM = {5'h1F, 7'($urandom)};
      run_frame(1'b1, 1'b0, 1'b0, "retire_approach");
    end
    n_checks++;
    if (BLOCK_START_X[39:30] !== 10'd67) $display("FAIL retire preload_x: got %0d want 67", BLOCK_START_X[39:30]);
    else n_pass++;
    run_frame(1'b1, 1'b0, 1'b0, "retire_frame");
    n_checks++;
    if (last_pass_mask !== (1 << 4)) $display("FAIL retire pulse: got %h want %h", last_pass_mask, 1 << 4);
    else n_pass++;
    n_checks++;
    if ({BLOCK_SHAPE[15:12], BLOCK_START_X[39:30], BLOCK_COLOR[11:9]} !== '0)
      $display("FAIL retire slot1_cleared: got %h want 0", {BLOCK_SHAPE[15:12], BLOCK_START_X[39:30], BLOCK_COLOR[11:9]});
    else n_pass++;
  endtask

  task automatic test_zero_sub();
    apply_reset();
    SPEED  = 4'd8;
    RANDOM = 12'h000;
    run_frame(1'b1, 1'b0, 1'b0, "zero_sub_spawn");
    n_checks++;
    if ({BLOCK_SHAPE[15:12], BLOCK_COLOR[11:9]} !== {4'd1, 3'd1})
      $display("FAIL zero_sub shape_color: got %h want %h", {BLOCK_SHAPE[15:12], BLOCK_COLOR[11:9]}, {4'd1, 3'd1});
    else n_pass++;
    for (int f = 1; f <= 20; f++) begin
      run_frame(1'b1, 1'b0, 1'b0, "zero_sub_gap");
      if (f == 19) begin
        n_checks++;
        if (BLOCK_SHAPE[11:8] !== 4'd0) $display("FAIL zero_sub gap_early: got %0d want 0", BLOCK_SHAPE[11:8]);
        else n_pass++;
      end
    end
    n_checks++;
    if (BLOCK_SHAPE[11:8] !== 4'd1) $display("FAIL zero_sub gap_160: got %0d want 1", BLOCK_SHAPE[11:8]);
    else n_pass++;
  endtask

  task automatic test_freeze();
    int guard = 0;
    bit retired = 1'b0;
    apply_reset();
    SPEED = 4'd15;
    while (!model_full() && guard < 60) begin
      RANDOM = 12'($urandom);
      run_frame(1'b1, 1'b0, 1'b0, "freeze_fill");
      guard++;
    end
    n_checks++;
    if (BLOCK_SHAPE[15:12] === 4'd0 || BLOCK_SHAPE[11:8] === 4'd0 || BLOCK_SHAPE[7:4] === 4'd0 || BLOCK_SHAPE[3:0] === 4'd0)
      $display("FAIL freeze all_full: got %h want all slots nonzero", BLOCK_SHAPE);
    else n_pass++;
    for (int f = 0; f < 5; f++) begin
      RANDOM = 12'($urandom);
      run_frame(1'b0, 1'b0, 1'b0, "freeze_off");
    end
    guard = 0;
    while (!retired && guard < 60) begin
      RANDOM = 12'($urandom);
      run_frame(1'b1, 1'b0, 1'b0, "freeze_full_run");
      retired = (last_pass_mask != 0);
      guard++;
    end
    n_checks++;
    if (!retired) $display("FAIL freeze retire_timeout: got none want a retire within 60 frames");
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    SPEED  = 4'd7;
    RANDOM = 12'($urandom);
    run_frame(1'b1, 1'b0, 1'b1, "double_tick");
    RANDOM = 12'($urandom);
    run_frame(1'b1, 1'b1, 1'b0, "enable_drop_mid");
    RANDOM = 12'($urandom);
    run_frame(1'b0, 1'b0, 1'b0, "after_enable_drop");
  endtask

  task automatic test_reset_mid();
    SPEED  = 4'd5;
    ENABLE = 1'b1;
    V_SYNC = 1'b0;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (UPDATING !== 1'b1) $display("FAIL reset_mid in_sequence: got %b want 1", UPDATING);
    else n_pass++;
    RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({BLOCK_SHAPE, BLOCK_START_X, BLOCK_COLOR, PASSED, UPDATING} !== '0)
      $display("FAIL reset_mid async_clear: got %h want 0", {BLOCK_SHAPE, BLOCK_START_X, BLOCK_COLOR, PASSED, UPDATING});
    else n_pass++;
    @(negedge CLK);
    V_SYNC = 1'b1;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    model_clear();
    repeat (2) @(negedge CLK);
    RANDOM = 12'($urandom);
    run_frame(1'b1, 1'b0, 1'b0, "reset_mid_first_tick");
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      SPEED  = 4'($urandom_range(0, 15));
      RANDOM = 12'($urandom);
      run_frame(($urandom_range(0, 3) != 0), 1'b0, 1'b0, $sformatf("random_%0d", f));
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_scroll();
    test_retire();
    test_zero_sub();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
